// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter for a single
// shared memory port with a bidirectional data bus. Each access holds the
// memory port for ACCESS_CYCLES cycles, followed by one ack cycle.
// RR_EN selects round-robin (1) or fixed data priority (0) on contention.
// Optional build macro MEM_ARB_STATS_EN adds saturating per-port ack counters.
module mem_arbiter #(
    parameter int ACCESS_CYCLES = 4,
    parameter bit RR_EN         = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [11:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic [11:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_we,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [11:0] mem_addr,
    output logic        mem_read,
    output logic [1:0]  mem_write,
    inout  wire  [31:0] mem_bus,
    output logic        busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] if_cnt,
    output logic [15:0] d_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, ACK} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        last_d;
    logic [31:0] lat_wdata;
    logic        drive_en;
    logic        grant_d;
    logic        grant_i;
    logic        d_is_write;
    logic        acc_last;

    // Winner selection for the current cycle; only acted upon in IDLE.
    always_comb begin
        grant_d    = d_req && (!if_req || !RR_EN || !last_d);
        grant_i    = if_req && !grant_d;
        d_is_write = (d_we == 2'd1) || (d_we == 2'd3);
        acc_last   = ((state == ACC_I) || (state == ACC_D)) && (cnt == LAST_CNT);
    end

    // The bus is driven only while a data write occupies the memory port.
    assign mem_bus = drive_en ? lat_wdata : 32'hzzzz_zzzz;

    assign busy = (state != IDLE);

    // Main arbitration FSM; all memory-side outputs and acks are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last_d    <= 1'b0;
            lat_wdata <= 32'd0;
            drive_en  <= 1'b0;
            mem_addr  <= 12'd0;
            mem_read  <= 1'b0;
            mem_write <= 2'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (grant_d) begin
                        state    <= ACC_D;
                        last_d   <= 1'b1;
                        mem_addr <= d_addr;
                        if (d_is_write) begin
                            mem_read  <= 1'b0;
                            mem_write <= d_we;
                            lat_wdata <= d_wdata;
                            drive_en  <= 1'b1;
                        end else begin
                            mem_read  <= 1'b1;
                            mem_write <= 2'd0;
                            drive_en  <= 1'b0;
                        end
                    end else if (grant_i) begin
                        state     <= ACC_I;
                        last_d    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_read  <= 1'b1;
                        mem_write <= 2'd0;
                        drive_en  <= 1'b0;
                    end
                end
                ACC_I, ACC_D: begin
                    if (cnt == LAST_CNT) begin
                        state     <= ACK;
                        cnt       <= 4'd0;
                        mem_addr  <= 12'd0;
                        mem_read  <= 1'b0;
                        mem_write <= 2'd0;
                        drive_en  <= 1'b0;
                        if (state == ACC_I) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_bus;
                        end else begin
                            d_ack <= 1'b1;
                            if (mem_read) begin
                                d_rdata <= mem_bus;
                            end
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Saturating ack counters, bumped as each port's ack is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_cnt <= 16'd0;
            d_cnt  <= 16'd0;
        end else if (acc_last) begin
            if ((state == ACC_I) && (if_cnt != 16'hFFFF)) begin
                if_cnt <= if_cnt + 16'd1;
            end
            if ((state == ACC_D) && (d_cnt != 16'hFFFF)) begin
                d_cnt <= d_cnt + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed self-checking bench for mem_arbiter.
// A transaction-level scheduler predicts, for every cycle, which access owns
// the memory port and when its ack and read data appear.
module tb_mem_arbiter;

    localparam int AC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [11:0] if_addr;
    logic        d_req;
    logic [11:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_we;

    logic [31:0] if_rdata, d_rdata;
    logic        if_ack, d_ack, mem_read, busy;
    logic [11:0] mem_addr;
    logic [1:0]  mem_write;
    wire  [31:0] mem_bus;

    logic [31:0] f_if_rdata, f_d_rdata;
    logic        f_if_ack, f_d_ack, f_mem_read, f_busy;
    logic [11:0] f_mem_addr;
    logic [1:0]  f_mem_write;
    wire  [31:0] f_mem_bus;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] if_cnt, d_cnt, f_if_cnt, f_d_cnt;
`endif

    int vectors = 0;
    int fails   = 0;

    // Memory contents as seen by the bench: a fixed word at 0x020, hash elsewhere.
    function automatic logic [31:0] mem_data(input logic [11:0] a);
        if (a == 12'h020) return 32'h1234_5678;
        return ({20'd0, a} * 32'h9E37_79B9) ^ 32'h0000_5A5A;
    endfunction

    assign mem_bus   = mem_read   ? mem_data(mem_addr)   : 32'hzzzz_zzzz;
    assign f_mem_bus = f_mem_read ? mem_data(f_mem_addr) : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    mem_arbiter #(.ACCESS_CYCLES(AC), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_bus(mem_bus), .busy(busy)
`ifdef MEM_ARB_STATS_EN
        , .if_cnt(if_cnt), .d_cnt(d_cnt)
`endif
    );

    mem_arbiter #(.ACCESS_CYCLES(AC), .RR_EN(1'b0)) u_fixed (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(f_if_rdata), .if_ack(f_if_ack),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_rdata(f_d_rdata), .d_ack(f_d_ack),
        .mem_addr(f_mem_addr), .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_bus(f_mem_bus), .busy(f_busy)
`ifdef MEM_ARB_STATS_EN
        , .if_cnt(f_if_cnt), .d_cnt(f_d_cnt)
`endif
    );

    // Reference model: one scheduled transaction at a time.
    int          cur;
    int          free_at;
    int          g_t;
    bit          g_port;
    bit          g_wr;
    logic [11:0] g_addr;
    logic [1:0]  g_we;
    logic [31:0] g_wd;
    bit          last_d;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    int          exp_if_cnt, exp_d_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s @%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic resetModel();
        free_at      = cur;
        g_t          = -100;
        g_port       = 1'b0;
        g_wr         = 1'b0;
        last_d       = 1'b0;
        exp_if_rdata = 32'd0;
        exp_d_rdata  = 32'd0;
        exp_if_cnt   = 0;
        exp_d_cnt    = 0;
    endtask

    // Decide what the coming clock edge does with the inputs now applied.
    task automatic modelStep();
        bit win_d;
        if (cur >= free_at && (if_req || d_req)) begin
            win_d  = d_req && (!if_req || !last_d);
            g_t    = cur;
            g_port = win_d;
            g_addr = win_d ? d_addr : if_addr;
            g_we   = win_d ? d_we : 2'd0;
            g_wd   = d_wdata;
            g_wr   = win_d && (d_we == 2'd1 || d_we == 2'd3);
            last_d = win_d;
            free_at = cur + AC + 2;
        end
        cur++;
    endtask

    // Compare every observable output with the schedule for the current cycle.
    task automatic checkCycle();
        bit acc, ackc;
        acc  = (cur >= g_t + 1) && (cur <= g_t + AC);
        ackc = (cur == g_t + AC + 1);
        if (ackc) begin
            if (!g_wr) begin
                if (g_port) exp_d_rdata = mem_data(g_addr);
                else        exp_if_rdata = mem_data(g_addr);
            end
            if (g_port) exp_d_cnt = (exp_d_cnt < 65535) ? exp_d_cnt + 1 : exp_d_cnt;
            else        exp_if_cnt = (exp_if_cnt < 65535) ? exp_if_cnt + 1 : exp_if_cnt;
        end
        checkOutput("busy",      {31'd0, busy},      {31'd0, acc || ackc});
        checkOutput("if_ack",    {31'd0, if_ack},    {31'd0, ackc && !g_port});
        checkOutput("d_ack",     {31'd0, d_ack},     {31'd0, ackc && g_port});
        checkOutput("mem_read",  {31'd0, mem_read},  {31'd0, acc && !g_wr});
        checkOutput("mem_write", {30'd0, mem_write}, {30'd0, (acc && g_wr) ? g_we : 2'd0});
        checkOutput("if_rdata",  if_rdata, exp_if_rdata);
        checkOutput("d_rdata",   d_rdata,  exp_d_rdata);
        if (acc) checkOutput("mem_addr", {20'd0, mem_addr}, {20'd0, g_addr});
        if (acc && g_wr) checkOutput("mem_bus_wdata", mem_bus, g_wd);
`ifdef MEM_ARB_STATS_EN
        checkOutput("if_cnt", {16'd0, if_cnt}, exp_if_cnt);
        checkOutput("d_cnt",  {16'd0, d_cnt},  exp_d_cnt);
`endif
    endtask

    task automatic applyStimulus(input logic ir, input logic [11:0] ia, input logic dr,
                                 input logic [11:0] da, input logic [31:0] wd, input logic [1:0] we);
        @(negedge clk);
        checkCycle();
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_addr  = da;
        d_wdata = wd;
        d_we    = we;
        modelStep();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 32'd0, 2'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int f_d_acks, f_if_acks, r_d_acks, r_if_acks;
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = '0;
        cur = 0;
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",      {31'd0, busy},      32'd0);
        checkOutput("rst_mem_read",  {31'd0, mem_read},  32'd0);
        checkOutput("rst_mem_write", {30'd0, mem_write}, 32'd0);
        checkOutput("rst_mem_addr",  {20'd0, mem_addr},  32'd0);
        checkOutput("rst_acks",      {30'd0, if_ack, d_ack}, 32'd0);
        checkOutput("rst_rdata",     if_rdata | d_rdata, 32'd0);
        rst = 1'b1;
        resetModel();
        modelStep();

        $display("[TB] word write to 0x010, inputs scrambled during the access");
        applyStimulus(1'b0, 12'h000, 1'b1, 12'h010, 32'hDEAD_BEEF, 2'd1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 12'h3FF, 1'b0, 12'hABC, 32'h0BAD_0BAD, 2'd3);

        $display("[TB] fetch from 0x020");
        applyStimulus(1'b1, 12'h020, 1'b0, 12'h000, 32'd0, 2'd0);
        idleCycles(6);
        checkOutput("fetch_0x020", if_rdata, 32'h1234_5678);

        $display("[TB] both ports requesting continuously");
        f_d_acks = 0; f_if_acks = 0; r_d_acks = 0; r_if_acks = 0;
        for (int i = 0; i < 26; i++) begin
            applyStimulus(1'b1, 12'(12'h100 + i), 1'b1, 12'(12'h200 + i), 32'(i), 2'(i % 4));
            f_d_acks  += int'(f_d_ack);
            f_if_acks += int'(f_if_ack);
            r_d_acks  += int'(d_ack);
            r_if_acks += int'(if_ack);
        end
        checkOutput("fixed_d_acks",  f_d_acks,  32'd4);
        checkOutput("fixed_if_acks", f_if_acks, 32'd0);
        checkOutput("rr_d_acks",     r_d_acks,  32'd2);
        checkOutput("rr_if_acks",    r_if_acks, 32'd2);
        idleCycles(8);

        $display("[TB] reset during the second cycle of a byte write");
        applyStimulus(1'b0, 12'h000, 1'b1, 12'h0A5, 32'hCAFE_F00D, 2'd3);
        applyStimulus(1'b0, 12'h000, 1'b0, 12'h000, 32'd0, 2'd0);
        @(posedge clk);
        #2;
        checkOutput("pre_rst_mem_write", {30'd0, mem_write}, 32'd3);
        checkOutput("pre_rst_mem_bus",   mem_bus, 32'hCAFE_F00D);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_mem_write", {30'd0, mem_write}, 32'd0);
        checkOutput("mid_rst_busy",      {31'd0, busy},      32'd0);
        checkOutput("mid_rst_d_ack",     {31'd0, d_ack},     32'd0);
        @(negedge clk);
        rst = 1'b1;
        resetModel();
        modelStep();
        idleCycles(8);

        $display("[TB] first tie after reset");
        applyStimulus(1'b1, 12'h111, 1'b1, 12'h222, 32'h1, 2'd2);
        idleCycles(7);
        checkOutput("tie_d_rdata", d_rdata, mem_data(12'h222));

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)),
                          12'($urandom), $urandom, 2'($urandom_range(0, 3)));
        end
        idleCycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 4: cycles each memory access is held on the memory port (legal 2..15, even).
REQ-002 SHALL have parameter RR_EN, default 1: 1 = round-robin on contention, 0 = fixed data-port priority.
REQ-003 Ports: clk  input  1  single clock, all state on posedge.
REQ-004 Ports: rst  input  1  asynchronous, active-low reset.
REQ-005 Ports: if_req  input  1  instruction fetch request; if_addr  input  12  fetch address.
REQ-006 Ports: if_rdata  output  32  fetch data; if_ack  output  1  one-cycle completion pulse.
REQ-007 Ports: d_req  input  1  data request; d_addr  input  12  data address; d_wdata  input  32  store data.
REQ-008 Ports: d_we  input  2  access type: 0 = read, 1 = word write, 3 = byte write; 2 is reserved and treated as read.
REQ-009 Ports: d_rdata  output  32  load data; d_ack  output  1  one-cycle completion pulse.
REQ-010 Ports: mem_addr  output  12; mem_read  output  1; mem_write  output  2; mem_bus  inout  32  memory data bus.
REQ-011 Ports: busy  output  1  high while a transaction is granted.

Function
REQ-012 SHALL use the FSM states IDLE, ACC_I, ACC_D and ACK.
REQ-013 IDLE: d_req only -> ACC_D; if_req only -> ACC_I; neither -> stay in IDLE.
REQ-014 Both requests in IDLE with RR_EN=1 SHALL grant the port not served last; the reset value of last-served is instruction, so data wins the first tie.
REQ-015 Both requests in IDLE with RR_EN=0 SHALL always grant data.
REQ-016 On grant, the arbiter SHALL latch the winner's addr, we and wdata, and SHALL ignore later changes to them.
REQ-017 In ACC_x, mem_addr = the latched address for exactly ACCESS_CYCLES cycles, counted by a 4-bit counter.
REQ-018 In ACC_x for a read, mem_read = 1 and mem_write = 0.
REQ-019 In ACC_x for a write, mem_read = 0, mem_write = the latched we, and mem_bus is driven with the latched wdata.
REQ-020 mem_bus SHALL be high-Z whenever no write is in ACC_D; mem_read and a bus drive SHALL never be active in the same cycle.
REQ-021 On the last ACC cycle of a read, mem_bus SHALL be registered into if_rdata or d_rdata; rdata holds until the next read on that port.
REQ-022 ACK SHALL last one cycle and pulse the winner's ack; the next state is always IDLE, so grant-to-ack latency = ACCESS_CYCLES+1 and back-to-back throughput = one access per ACCESS_CYCLES+2 cycles.
REQ-023 A request deasserted mid-access SHALL not abort it; the access completes and ack still pulses.
REQ-024 A request still high in the cycle after ack SHALL be treated as a new request.
REQ-025 busy = 1 in ACC_I, ACC_D and ACK, and 0 in IDLE.
REQ-026 The fetch port SHALL always perform a read, with mem_write = 0.

Reset
REQ-027 rst low SHALL asynchronously force: state IDLE, counter 0, last-served = instruction, mem_read = 0, mem_write = 0, mem_addr = 0, mem_bus high-Z, both acks 0, both rdata 0, busy 0.
REQ-028 Reset during ACC_x SHALL abandon the access; no ack is issued and no write is retried after release.

Configuration
REQ-029 Macro MEM_ARB_STATS_EN defined: add outputs if_cnt[15:0] and d_cnt[15:0], incremented on each ack of that port, saturating at 0xFFFF, cleared by rst.
REQ-030 Macro MEM_ARB_STATS_EN undefined: the outputs and counters SHALL not exist, and all other behaviour is identical.

Verification
REQ-031 ACCESS_CYCLES=4, d_req with d_we=1, d_addr=0x010, d_wdata=0xDEADBEEF -> mem_write=1, mem_addr=0x010, mem_bus=0xDEADBEEF for 4 cycles; d_ack in cycle 5 after grant.
REQ-032 Fetch read at 0x020 with the memory model returning 0x12345678 -> if_rdata=0x12345678 together with the if_ack pulse; mem_bus never driven by the arbiter.
REQ-033 if_req and d_req held high continuously with RR_EN=1 -> grants alternate D, I, D, I; each port gets one ack per 12 cycles.
REQ-034 Same stimulus with RR_EN=0 -> only d_ack pulses and if_ack stays 0.
REQ-035 rst pulsed low in cycle 2 of a write -> mem_write=0 and mem_bus high-Z immediately; no d_ack after release.
REQ-036 MEM_ARB_STATS_EN defined, d_cnt preloaded to 0xFFFE via 0xFFFE acks (or force) -> after two more data acks d_cnt=0xFFFF.
